// File: rtl/ts_failover_scheduler.sv
// ts_failover_scheduler
// Selects one of four transport-stream input channels for the output mux.
// Per-channel health is derived from a saturating packet-error counter and
// a loss-of-sync (LOS) timer. A four-state FSM (IDLE/PEND/HOLD/LOCK) moves
// the mux only on a sync byte of the new channel, so a switch never lands
// mid-packet. After each switch, a holdoff of HOLDOFF_PKTS syncs suppresses
// further voluntary switches.
// Optional feature: define QOS_FORCE_EN to enable the forced-channel mode
// (cfg_force_en / cfg_force_ch). Without the macro those ports are ignored.
module ts_failover_scheduler #(
  parameter int ERR_THRESH   = 4,
  parameter int SYNC_TIMEOUT = 2048,
  parameter int HOLDOFF_PKTS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sync,
  input  logic [3:0] valid,
  input  logic [3:0] err_inc,
  input  logic       clr_err,
  input  logic [7:0] cfg_prio,
  input  logic       cfg_force_en,
  input  logic [1:0] cfg_force_ch,
  output logic [1:0] mux_control,
  output logic       switch_pulse,
  output logic [1:0] state,
  output logic [3:0] healthy,
  output logic       all_fail
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PEND = 2'b01,
    ST_HOLD = 2'b10,
    ST_LOCK = 2'b11
  } state_e;

  localparam logic [4:0]  ERR_TH   = 5'(ERR_THRESH);
  localparam logic [15:0] LOS_MAX  = 16'(SYNC_TIMEOUT);
  localparam logic [15:0] HOLD_MAX = 16'(HOLDOFF_PKTS);

  // Counters and health
  logic [3:0]  err_cnt_q [4];
  logic [3:0]  err_cnt_d [4];
  logic [15:0] los_cnt_q [4];
  logic [15:0] los_cnt_d [4];
  logic [3:0]  healthy_q;
  logic [3:0]  healthy_d;
  logic        all_fail_q;
  logic        all_fail_d;

  // FSM and mux
  state_e      state_q;
  state_e      state_d;
  logic [1:0]  target_q;
  logic [1:0]  target_d;
  logic [1:0]  mux_q;
  logic [1:0]  mux_d;
  logic        pulse_q;
  logic        pulse_d;
  logic [15:0] hold_q;
  logic [15:0] hold_d;

  // Combinational helpers
  logic [3:0]  sv_s;
  logic        best_valid_s;
  logic [1:0]  best_s;
  logic [2:0]  best_rank_s;
  logic [2:0]  cur_rank_s;
  logic        tgt_ok_s;
  logic        lock_switch_s;

  assign sv_s = sync & valid;

  // Error counters, LOS timers and the next health vector
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      err_cnt_d[i] = err_cnt_q[i];
      los_cnt_d[i] = los_cnt_q[i];
      if (clr_err) begin
        // A simultaneous error is not lost: the counter restarts at 1
        err_cnt_d[i] = {3'b000, err_inc[i]};
      end else if (err_inc[i] && (err_cnt_q[i] != 4'hF)) begin
        err_cnt_d[i] = err_cnt_q[i] + 4'd1;
      end else begin
        err_cnt_d[i] = err_cnt_q[i];
      end
      if (sv_s[i]) begin
        los_cnt_d[i] = 16'd0;
      end else if (los_cnt_q[i] != LOS_MAX) begin
        los_cnt_d[i] = los_cnt_q[i] + 16'd1;
      end else begin
        los_cnt_d[i] = los_cnt_q[i];
      end
      healthy_d[i] = ({1'b0, err_cnt_q[i]} < ERR_TH) && (los_cnt_q[i] != LOS_MAX);
    end
    all_fail_d = (healthy_d == 4'b0000);
  end

  // Register counters and health
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        err_cnt_q[i] <= 4'd0;
        los_cnt_q[i] <= 16'd0;
      end
      healthy_q  <= 4'b1111;
      all_fail_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        err_cnt_q[i] <= err_cnt_d[i];
        los_cnt_q[i] <= los_cnt_d[i];
      end
      healthy_q  <= healthy_d;
      all_fail_q <= all_fail_d;
    end
  end

  // Best channel: first healthy entry in the priority list, plus list ranks
  always_comb begin
    best_valid_s = 1'b0;
    best_s       = 2'd0;
    best_rank_s  = 3'd4;
    cur_rank_s   = 3'd4;
    for (int k = 0; k < 4; k++) begin
      if (!best_valid_s && healthy_q[cfg_prio[2*k +: 2]]) begin
        best_valid_s = 1'b1;
        best_s       = cfg_prio[2*k +: 2];
        best_rank_s  = 3'(k);
      end else begin
        best_valid_s = best_valid_s;
      end
      // Rank of the current channel is its first appearance in the list
      if ((cur_rank_s == 3'd4) && (cfg_prio[2*k +: 2] == mux_q)) begin
        cur_rank_s = 3'(k);
      end else begin
        cur_rank_s = cur_rank_s;
      end
    end
`ifdef QOS_FORCE_EN
    if (cfg_force_en) begin
      best_valid_s = 1'b1;
      best_s       = cfg_force_ch;
    end else begin
      best_s       = best_s;
    end
`endif
  end

`ifdef QOS_FORCE_EN
  // A forced target is acceptable even when unhealthy; forcing replaces revertive moves
  always_comb begin
    tgt_ok_s      = healthy_q[target_q] || (cfg_force_en && (target_q == cfg_force_ch));
    if (cfg_force_en) begin
      lock_switch_s = (best_s != mux_q);
    end else begin
      lock_switch_s = (!healthy_q[mux_q] && (best_s != mux_q)) || (best_rank_s < cur_rank_s);
    end
  end
`else
  logic unused_force_s;
  assign unused_force_s = ^{cfg_force_en, cfg_force_ch};

  // Target validity and LOCK switching rule (failover or revertive)
  always_comb begin
    tgt_ok_s      = healthy_q[target_q];
    lock_switch_s = (!healthy_q[mux_q] && (best_s != mux_q)) || (best_rank_s < cur_rank_s);
  end
`endif

  // Switch FSM next-state and mux decisions
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    mux_d    = mux_q;
    pulse_d  = 1'b0;
    hold_d   = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (best_valid_s) begin
          target_d = best_s;
          state_d  = ST_PEND;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (!tgt_ok_s) begin
          // Target failed before its sync arrived: retarget or give up
          if (best_valid_s) begin
            target_d = best_s;
          end else begin
            state_d  = ST_IDLE;
          end
        end else if (sv_s[target_q]) begin
          // Commit exactly on the target's sync byte
          mux_d   = target_q;
          pulse_d = 1'b1;
          hold_d  = 16'd0;
          state_d = ST_HOLD;
        end else begin
          state_d = ST_PEND;
        end
      end
      ST_HOLD: begin
        if (!healthy_q[mux_q] && best_valid_s && (best_s != mux_q)) begin
          // Failure overrides the holdoff
          target_d = best_s;
          state_d  = ST_PEND;
        end else if (hold_q >= HOLD_MAX) begin
          state_d  = ST_LOCK;
        end else if (sv_s[mux_q]) begin
          hold_d   = hold_q + 16'd1;
        end else begin
          hold_d   = hold_q;
        end
      end
      ST_LOCK: begin
        if (best_valid_s && lock_switch_s) begin
          target_d = best_s;
          state_d  = ST_PEND;
        end else begin
          // No healthy channel or nothing better: keep the current mux
          state_d  = ST_LOCK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register FSM state, mux select and switch pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      target_q <= 2'd0;
      mux_q    <= 2'd0;
      pulse_q  <= 1'b0;
      hold_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      mux_q    <= mux_d;
      pulse_q  <= pulse_d;
      hold_q   <= hold_d;
    end
  end

  assign mux_control  = mux_q;
  assign switch_pulse = pulse_q;
  assign state        = state_q;
  assign healthy      = healthy_q;
  assign all_fail     = all_fail_q;

endmodule
